// File: rtl/hamming_pkg.sv
// Shared types, constants and helpers for the pairwise Hamming-distance engine.
package hamming_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        LDA_HI,
        LDA_LO,
        LDB_HI,
        LDB_LO,
        CMP,
        WR_MIN,
        WR_MAX,
        DONE
    } state_t;

    localparam logic [5:0] NUM_OPS   = 6'd32;
    localparam logic [5:0] LAST_I    = NUM_OPS - 6'd1;
    localparam int         OP_W      = 16;
    localparam int         MEM_DEPTH = 256;
    localparam logic [7:0] MIN_ADDR  = 8'd64;
    localparam logic [7:0] MAX_ADDR  = 8'd65;
    localparam logic [4:0] DIST_CEIL = 5'd16;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int k = 0; k < 16; k++) begin
            c = c + {4'b0, v[k]};
        end
        return c;
    endfunction

endpackage

// File: rtl/hamming_top_level_data_mem.sv
// Byte-wide data memory: combinational read, posedge write, never cleared by reset.
module data_mem
    import hamming_pkg::*;
(
    input  logic       clk,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    input  logic       wr_en,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data
);

    logic [7:0] core [MEM_DEPTH];

    assign rd_data = core[rd_addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            core[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/hamming_top_level.sv
// Walks every operand pair i<j, tracking min/max popcount(A^B), then writes both results.
module hamming_top_level
    import hamming_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic done
);

    state_t          state_q;
    logic [5:0]      i_q, j_q;
    logic [OP_W-1:0] opA_q, opB_q;
    logic [4:0]      minDist_q, maxDist_q;
    logic            done_q;

    logic [5:0] iInc_d, jInc_d;
    logic [4:0] dist_d;
    logic [7:0] rdAddr, rdData, wrAddr, wrData;
    logic       wrEn;

    data_mem dm (
        .clk     (clk),
        .rd_addr (rdAddr),
        .rd_data (rdData),
        .wr_en   (wrEn),
        .wr_addr (wrAddr),
        .wr_data (wrData)
    );

    assign done   = done_q;
    assign iInc_d = i_q + 6'd1;
    assign jInc_d = j_q + 6'd1;
    assign dist_d = popcount16(opA_q ^ opB_q);

    always_comb begin
        rdAddr = '0;
        case (state_q)
            LDA_HI:  rdAddr = {1'b0, i_q, 1'b0};
            LDA_LO:  rdAddr = {1'b0, i_q, 1'b1};
            LDB_HI:  rdAddr = {1'b0, j_q, 1'b0};
            LDB_LO:  rdAddr = {1'b0, j_q, 1'b1};
            default: rdAddr = '0;
        endcase
    end

    // Gated by start/reset so an abort landing on a write state leaves memory untouched.
    assign wrEn   = rst_n && !start && (state_q == WR_MIN || state_q == WR_MAX);
    assign wrAddr = (state_q == WR_MAX) ? MAX_ADDR : MIN_ADDR;
    assign wrData = {3'b0, (state_q == WR_MAX) ? maxDist_q : minDist_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            opA_q     <= '0;
            opB_q     <= '0;
            minDist_q <= '0;
            maxDist_q <= '0;
            done_q    <= 1'b0;
        end else if (start) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: state_q <= INIT;
                INIT: begin
                    minDist_q <= DIST_CEIL;
                    maxDist_q <= '0;
                    i_q       <= '0;
                    j_q       <= 6'd1;
                    state_q   <= LDA_HI;
                end
                LDA_HI: begin
                    opA_q[15:8] <= rdData;
                    state_q     <= LDA_LO;
                end
                LDA_LO: begin
                    opA_q[7:0] <= rdData;
                    state_q    <= LDB_HI;
                end
                LDB_HI: begin
                    opB_q[15:8] <= rdData;
                    state_q     <= LDB_LO;
                end
                LDB_LO: begin
                    opB_q[7:0] <= rdData;
                    state_q    <= CMP;
                end
                CMP: begin
                    // Strict compares so ties keep the earlier pair's value.
                    if (dist_d < minDist_q) minDist_q <= dist_d;
                    if (dist_d > maxDist_q) maxDist_q <= dist_d;
                    if (jInc_d == NUM_OPS) begin
                        if (iInc_d == LAST_I) begin
                            state_q <= WR_MIN;
                        end else begin
                            i_q     <= iInc_d;
                            j_q     <= iInc_d + 6'd1;
                            state_q <= LDA_HI;
                        end
                    end else begin
                        j_q     <= jInc_d;
                        state_q <= LDB_HI;
                    end
                end
                WR_MIN: state_q <= WR_MAX;
                WR_MAX: begin
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE:    state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_top_level.sv
// Directed and model-checked runs of the Hamming min/max engine, including abort and reset mid-run.
module tb_hamming_top_level;

    typedef struct {
        int         pattern;
        bit         useModel;
        logic [4:0] expMin;
        logic [4:0] expMax;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic done;

    int checkCount = 0;
    int failCount  = 0;

    logic [15:0] ops [32];
    vec_t        vecs [8];
    logic [4:0]  expMin, expMax;

    always #5 clk = ~clk;

    hamming_top_level dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .done  (done)
    );

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic fillPattern(input int p);
        for (int k = 0; k < 32; k++) begin
            case (p)
                0:       ops[k] = 16'h0000;
                1:       ops[k] = (k == 1) ? 16'hFFFF : 16'h0000;
                2:       ops[k] = 16'h0001 << (k % 16);
                3:       ops[k] = 16'(k);
                4:       ops[k] = (k % 2 == 1) ? 16'hAAAA : 16'h5555;
                5:       ops[k] = 16'hFFFF;
                6:       ops[k] = 16'(k * 16'h0101 + 1);
                default: ops[k] = 16'($urandom);
            endcase
        end
    endtask

    task automatic modelMinMax(output logic [4:0] mn, output logic [4:0] mx);
        int d;
        mn = 5'd16;
        mx = 5'd0;
        for (int a = 0; a < 32; a++) begin
            for (int b = a + 1; b < 32; b++) begin
                d = $countones(ops[a] ^ ops[b]);
                if (d < int'(mn)) mn = 5'(d);
                if (d > int'(mx)) mx = 5'(d);
            end
        end
    endtask

    task automatic loadMem();
        for (int k = 0; k < 32; k++) begin
            dut.dm.core[2*k]   <= ops[k][15:8];
            dut.dm.core[2*k+1] <= ops[k][7:0];
        end
        dut.dm.core[64] <= 8'hEE;
        dut.dm.core[65] <= 8'hEE;
    endtask

    task automatic waitDone(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 3000 && !seen; n++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        checkOutput({name, ".doneWithinBudget"}, {7'b0, seen}, 8'd1);
    endtask

    task automatic applyStimulus(input string name);
        start = 1'b1;
        @(negedge clk);
        loadMem();
        @(negedge clk);
        checkOutput({name, ".doneLowWhileIdle"}, {7'b0, done}, 8'd0);
        start = 1'b0;
        waitDone(name);
    endtask

    task automatic checkResults(input string name, input logic [4:0] mn, input logic [4:0] mx);
        checkOutput({name, ".min"}, dut.dm.core[64], {3'b0, mn});
        checkOutput({name, ".max"}, dut.dm.core[65], {3'b0, mx});
    endtask

    task automatic holdAndRelease(input string name);
        repeat (5) @(negedge clk);
        checkOutput({name, ".doneHeld"}, {7'b0, done}, 8'd1);
        start = 1'b1;
        @(negedge clk);
        checkOutput({name, ".doneClearedByStart"}, {7'b0, done}, 8'd0);
    endtask

    initial begin
        vecs[0] = '{0, 1'b0, 5'd0, 5'd0};
        vecs[1] = '{1, 1'b0, 5'd0, 5'd16};
        vecs[2] = '{2, 1'b0, 5'd0, 5'd2};
        vecs[3] = '{3, 1'b0, 5'd1, 5'd5};
        vecs[4] = '{4, 1'b0, 5'd0, 5'd16};
        vecs[5] = '{5, 1'b0, 5'd0, 5'd0};
        vecs[6] = '{6, 1'b1, 5'd0, 5'd0};
        vecs[7] = '{7, 1'b1, 5'd0, 5'd0};

        rst_n = 1'b0;
        start = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset.done", {7'b0, done}, 8'd0);
        start = 1'b0;
        @(negedge clk);
        checkOutput("reset.priorityOverStart", {7'b0, done}, 8'd0);
        start = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            fillPattern(vecs[v].pattern);
            if (vecs[v].useModel) begin
                modelMinMax(expMin, expMax);
            end else begin
                expMin = vecs[v].expMin;
                expMax = vecs[v].expMax;
            end
            applyStimulus($sformatf("vec%0d", v));
            checkResults($sformatf("vec%0d", v), expMin, expMax);
            holdAndRelease($sformatf("vec%0d", v));
        end

        for (int r = 0; r < 10; r++) begin
            fillPattern(99);
            modelMinMax(expMin, expMax);
            applyStimulus($sformatf("rand%0d", r));
            checkResults($sformatf("rand%0d", r), expMin, expMax);
            holdAndRelease($sformatf("rand%0d", r));
        end

        $display("[TB] abort mid-run with start, then reload");
        fillPattern(0);
        start = 1'b1;
        @(negedge clk);
        loadMem();
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        checkOutput("abort.done", {7'b0, done}, 8'd0);
        checkOutput("abort.noMinWrite", dut.dm.core[64], 8'hEE);
        checkOutput("abort.noMaxWrite", dut.dm.core[65], 8'hEE);
        fillPattern(2);
        loadMem();
        @(negedge clk);
        start = 1'b0;
        waitDone("abort.rerun");
        checkResults("abort.rerun", 5'd0, 5'd2);
        holdAndRelease("abort.rerun");

        $display("[TB] reset pulse mid-run");
        fillPattern(4);
        start = 1'b1;
        @(negedge clk);
        loadMem();
        @(negedge clk);
        start = 1'b0;
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midReset.done", {7'b0, done}, 8'd0);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        checkOutput("midReset.noMinWrite", dut.dm.core[64], 8'hEE);
        checkOutput("midReset.noMaxWrite", dut.dm.core[65], 8'hEE);
        start = 1'b0;
        waitDone("midReset.rerun");
        checkResults("midReset.rerun", 5'd0, 5'd16);
        holdAndRelease("midReset.rerun");

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
